// File: rtl/univ_shift_reg_pkg.sv
// Mode encodings shared by the universal shift register and its bench.
package univ_shift_reg_pkg;

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_LOAD  = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_SHR   = 3'b011;
  localparam logic [2:0] MODE_ROL   = 3'b100;
  localparam logic [2:0] MODE_ROR   = 3'b101;
  localparam logic [2:0] MODE_ASR   = 3'b110;
  localparam logic [2:0] MODE_CLEAR = 3'b111;

endpackage

// File: rtl/shift_cnt.sv
// Saturating count of shifts since the last load/clear, with a registered done flag.
module shift_cnt #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          done
);

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
    // done is computed from the next count so it rises on the same edge cnt reaches WIDTH.
    done_d = (cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign cnt  = cnt_q;
  assign done = done_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: load, shift, rotate, arithmetic shift and clear, with shift counter.
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int               CW      = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic [CW-1:0]    cnt,
  output logic             done
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             cnt_clr, cnt_inc;

  always_comb begin
    q_d     = q_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    if (en) begin
      unique case (mode)
        MODE_HOLD:  q_d = q_q;
        MODE_LOAD:  begin q_d = a;                             cnt_clr = 1'b1; end
        MODE_SHL:   begin q_d = {q_q[WIDTH-2:0], sin_r};       cnt_inc = 1'b1; end
        MODE_SHR:   begin q_d = {sin_l, q_q[WIDTH-1:1]};       cnt_inc = 1'b1; end
        MODE_ROL:   begin q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]}; cnt_inc = 1'b1; end
        MODE_ROR:   begin q_d = {q_q[0], q_q[WIDTH-1:1]};      cnt_inc = 1'b1; end
        MODE_ASR:   begin q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]}; cnt_inc = 1'b1; end
        MODE_CLEAR: begin q_d = '0;                            cnt_clr = 1'b1; end
        default:    q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  shift_cnt #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_shift_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .cnt  (cnt),
    .done (done)
  );

  assign q      = q_q;
  // Serial outputs are unregistered so the outgoing bit is visible before the shift edge.
  assign sout_l = q_q[WIDTH-1];
  assign sout_r = q_q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed scoreboard bench for univ_shift_reg (WIDTH=4, RST_VAL=0).
module tb_univ_shift_reg;
  import univ_shift_reg_pkg::*;

  localparam int W  = 4;
  localparam int CW = 3;
  localparam int EW = W + CW + 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [2:0]    mode = MODE_HOLD;
  logic [W-1:0]  a = '0;
  logic          sin_l = 1'b0;
  logic          sin_r = 1'b0;
  logic [W-1:0]  q;
  logic          sout_l, sout_r;
  logic [CW-1:0] cnt;
  logic          done;

  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  int            checks = 0;
  int            errors = 0;
  event          chk_now;

  univ_shift_reg #(.WIDTH(W), .RST_VAL(4'b0000)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .mode   (mode),
    .a      (a),
    .sin_l  (sin_l),
    .sin_r  (sin_r),
    .q      (q),
    .sout_l (sout_l),
    .sout_r (sout_r),
    .cnt    (cnt),
    .done   (done)
  );

  // clock / reset
  always #5 clk = ~clk;

  // expected vector layout: {q, cnt, done, sout_l, sout_r}
  task automatic push_exp(input string name, input logic [W-1:0] eq,
                          input logic [CW-1:0] ecnt, input logic edone);
    exp_q.push_back({eq, ecnt, edone, eq[W-1], eq[0]});
    name_q.push_back(name);
  endtask

  // drivers
  task automatic op(input string name, input logic ien, input logic [2:0] imode,
                    input logic [W-1:0] ia, input logic isl, input logic isr,
                    input logic [W-1:0] eq, input logic [CW-1:0] ecnt, input logic edone);
    @(negedge clk);
    #1;
    en    = ien;
    mode  = imode;
    a     = ia;
    sin_l = isl;
    sin_r = isr;
    @(posedge clk);
    push_exp(name, eq, ecnt, edone);
  endtask

  task automatic assert_rst(input string name);
    @(negedge clk);
    #1;
    en  = 1'b0;
    rst = 1'b1;
    #1;
    push_exp(name, 4'b0000, 3'd0, 1'b0);
    -> chk_now;
  endtask

  task automatic release_rst();
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  // scoreboard monitor
  initial begin
    logic [EW-1:0] exp_v, got_v;
    string         nm;
    forever begin
      @(negedge clk or chk_now);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        nm    = name_q.pop_front();
        got_v = {q, cnt, done, sout_l, sout_r};
        checks++;
        if (got_v !== exp_v) begin
          errors++;
          $display("FAIL %s: got q=%b cnt=%0d done=%b sl=%b sr=%b, want q=%b cnt=%0d done=%b sl=%b sr=%b",
                   nm, got_v[EW-1 -: W], got_v[CW+2:3], got_v[2], got_v[1], got_v[0],
                   exp_v[EW-1 -: W], exp_v[CW+2:3], exp_v[2], exp_v[1], exp_v[0]);
        end
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    #2;
    push_exp("reset_state", 4'b0000, 3'd0, 1'b0);
    -> chk_now;
    release_rst();

    op("load_1101", 1, MODE_LOAD, 4'b1101, 0, 0, 4'b1101, 3'd0, 0);
    op("shl_1",     1, MODE_SHL,  4'b0000, 0, 0, 4'b1010, 3'd1, 0);
    op("shl_2",     1, MODE_SHL,  4'b0000, 0, 0, 4'b0100, 3'd2, 0);
    op("shl_3",     1, MODE_SHL,  4'b0000, 0, 0, 4'b1000, 3'd3, 0);
    op("shl_4",     1, MODE_SHL,  4'b0000, 0, 0, 4'b0000, 3'd4, 1);
    op("shl_5_sat", 1, MODE_SHL,  4'b0000, 0, 1, 4'b0001, 3'd4, 1);

    op("load_1000", 1, MODE_LOAD, 4'b1000, 0, 0, 4'b1000, 3'd0, 0);
    op("ror",       1, MODE_ROR,  4'b0000, 1, 1, 4'b0100, 3'd1, 0);
    op("rol",       1, MODE_ROL,  4'b0000, 1, 1, 4'b1000, 3'd2, 0);
    op("asr_1",     1, MODE_ASR,  4'b0000, 0, 0, 4'b1100, 3'd3, 0);
    op("asr_2",     1, MODE_ASR,  4'b0000, 0, 0, 4'b1110, 3'd4, 1);

    op("load_0101", 1, MODE_LOAD, 4'b0101, 0, 0, 4'b0101, 3'd0, 0);
    op("shl_to_1010", 1, MODE_SHL, 4'b0000, 0, 0, 4'b1010, 3'd1, 0);
    for (int i = 0; i < 3; i++) begin
      op("en_low", 0, MODE_SHL, W'($urandom_range(0, 15)), 1, 1, 4'b1010, 3'd1, 0);
    end
    op("en_low_load", 0, MODE_LOAD, 4'b0111, 1, 1, 4'b1010, 3'd1, 0);
    op("hold",        1, MODE_HOLD, 4'b0111, 1, 1, 4'b1010, 3'd1, 0);
    op("clear",       1, MODE_CLEAR, 4'b0111, 1, 1, 4'b0000, 3'd0, 0);

    op("load_1101b", 1, MODE_LOAD, 4'b1101, 0, 0, 4'b1101, 3'd0, 0);
    op("mid_shl_1",  1, MODE_SHL,  4'b0000, 0, 0, 4'b1010, 3'd1, 0);
    op("mid_shl_2",  1, MODE_SHL,  4'b0000, 0, 0, 4'b0100, 3'd2, 0);
    assert_rst("async_rst_mid");
    @(posedge clk);
    push_exp("rst_held", 4'b0000, 3'd0, 1'b0);
    release_rst();
    op("post_rst_load", 1, MODE_LOAD, 4'b1000, 0, 0, 4'b1000, 3'd0, 0);
    op("post_rst_shl",  1, MODE_SHL,  4'b0000, 0, 0, 4'b0000, 3'd1, 0);

    op("load_0001", 1, MODE_LOAD, 4'b0001, 0, 0, 4'b0001, 3'd0, 0);
    op("shr_1",     1, MODE_SHR,  4'b0000, 1, 0, 4'b1000, 3'd1, 0);
    op("shr_2",     1, MODE_SHR,  4'b0000, 1, 0, 4'b1100, 3'd2, 0);
    op("shr_3",     1, MODE_SHR,  4'b0000, 1, 0, 4'b1110, 3'd3, 0);
    op("shr_4",     1, MODE_SHR,  4'b0000, 1, 0, 4'b1111, 3'd4, 1);

    @(negedge clk);
    #1;
    en = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left unchecked, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
